// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: memory op codes, FSM states, byte-enable patterns.
package load_store_unit_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Lane logic for one memory access: byte enables, store replication,
// alignment check and load extraction/extension. Purely combinational.
module load_store_align
  import load_store_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            op,
  input  logic [1:0]            offset,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [DATA_WIDTH-1:0] load_word,
  output logic [3:0]            be,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  misaligned,
  output logic [DATA_WIDTH-1:0] load_data
);

  logic [DATA_WIDTH-1:0] lane;

  always_comb begin
    lane       = load_word >> {offset, 3'b000};
    be         = BE_NONE;
    wdata      = store_data;
    misaligned = 1'b0;
    load_data  = '0;

    case (op)
      OP_LB, OP_LBU, OP_SB: be = BE_BYTE0 << offset;
      OP_LH, OP_LHU, OP_SH: begin
        be         = offset[1] ? BE_HALF_HI : BE_HALF_LO;
        misaligned = offset[0];
      end
      OP_LW, OP_SW: begin
        be         = BE_WORD;
        misaligned = |offset;
      end
      default: ;
    endcase

    case (op)
      OP_SB:   wdata = {(DATA_WIDTH/8){store_data[7:0]}};
      OP_SH:   wdata = {(DATA_WIDTH/16){store_data[15:0]}};
      default: ;
    endcase

    case (op)
      OP_LB:   load_data = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
      OP_LBU:  load_data = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
      OP_LH:   load_data = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
      OP_LHU:  load_data = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
      OP_LW:   load_data = load_word;
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one req/ack transaction per accepted op, then a single
// writeback pulse. Execute is stalled (ex_ready low) until the unit returns to IDLE.
//
// state  | meaning
// IDLE   | ex_ready high, waiting for an op
// ACCESS | dmem_req high, waiting for dmem_ack
// RESP   | wb_valid pulse with extended load data
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_OP_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [MEM_OP_WIDTH-1:0]   mem_op,
  input  logic [DATA_WIDTH-1:0]     addr,
  input  logic [DATA_WIDTH-1:0]     store_data,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [DATA_WIDTH-1:0]     dmem_addr,
  output logic [3:0]                dmem_be,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  input  logic                      dmem_ack,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata,
  output logic                      wb_valid,
  output logic                      wb_write,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      misaligned
);

  state_e                    state_q, state_d;
  logic [MEM_OP_WIDTH-1:0]   op_q;
  logic [1:0]                offset_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0]     rdata_q;

  logic                  accept, mem_access;
  logic [3:0]            req_be, rsp_be;
  logic [DATA_WIDTH-1:0] req_wdata, req_load_data, rsp_wdata, rsp_load_data;
  logic                  req_misaligned, rsp_misaligned;

  load_store_align #(.DATA_WIDTH(DATA_WIDTH)) u_req_align (
    .op         (mem_op),
    .offset     (addr[1:0]),
    .store_data (store_data),
    .load_word  ('0),
    .be         (req_be),
    .wdata      (req_wdata),
    .misaligned (req_misaligned),
    .load_data  (req_load_data)
  );

  load_store_align #(.DATA_WIDTH(DATA_WIDTH)) u_rsp_align (
    .op         (op_q),
    .offset     (offset_q),
    .store_data ('0),
    .load_word  (rdata_q),
    .be         (rsp_be),
    .wdata      (rsp_wdata),
    .misaligned (rsp_misaligned),
    .load_data  (rsp_load_data)
  );

  assign accept     = ex_valid && (state_q == ST_IDLE);
  assign mem_access = is_load(mem_op) || is_store(mem_op);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept && mem_access && !req_misaligned) state_d = ST_ACCESS;
      ST_ACCESS: if (dmem_ack) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request fields are only loaded on entry to ACCESS, so they stay frozen until ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      offset_q   <= '0;
      rd_q       <= '0;
      rdata_q    <= '0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      misaligned <= 1'b0;
    end else begin
      misaligned <= accept && mem_access && req_misaligned;
      if (state_q == ST_IDLE && state_d == ST_ACCESS) begin
        op_q       <= mem_op;
        offset_q   <= addr[1:0];
        rd_q       <= rd_addr;
        dmem_we    <= is_store(mem_op);
        dmem_addr  <= {addr[DATA_WIDTH-1:2], 2'b00};
        dmem_be    <= req_be;
        dmem_wdata <= req_wdata;
      end
      if (state_q == ST_ACCESS && dmem_ack) rdata_q <= dmem_rdata;
    end
  end

  assign ex_ready   = (state_q == ST_IDLE);
  assign dmem_req   = (state_q == ST_ACCESS);
  assign wb_valid   = (state_q == ST_RESP);
  assign wb_write   = wb_valid && is_load(op_q) && (rd_q != '0);
  assign wb_rd_addr = rd_q;
  assign wb_data    = (wb_valid && is_load(op_q)) ? rsp_load_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized bench for load_store_unit against a size/offset arithmetic model.
module tb_load_store_unit;

  localparam logic [3:0] T_NOP = 4'd0, T_LB = 4'd1, T_LH = 4'd2, T_LW = 4'd3, T_LBU = 4'd4,
                         T_LHU = 4'd5, T_SB = 4'd6, T_SH = 4'd7, T_SW = 4'd8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready;
  logic [3:0]  mem_op;
  logic [31:0] addr, store_data;
  logic [4:0]  rd_addr;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_write, misaligned;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .mem_op(mem_op), .addr(addr), .store_data(store_data), .rd_addr(rd_addr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_write(wb_write), .wb_rd_addr(wb_rd_addr),
    .wb_data(wb_data), .misaligned(misaligned)
  );

  task automatic check(input string nm, input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s/%s: observed %h expected %h", nm, tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, 0 for anything that is not a memory op.
  function automatic int m_size(input logic [3:0] op);
    case (op)
      T_LB, T_LBU, T_SB: return 1;
      T_LH, T_LHU, T_SH: return 2;
      T_LW, T_SW:        return 4;
      default:           return 0;
    endcase
  endfunction

  function automatic bit m_is_load(input logic [3:0] op);
    return (op == T_LB) || (op == T_LH) || (op == T_LW) || (op == T_LBU) || (op == T_LHU);
  endfunction

  function automatic bit m_misaligned(input logic [3:0] op, input logic [31:0] a);
    int sz = m_size(op);
    return (sz > 1) && ((a % sz) != 0);
  endfunction

  function automatic logic [31:0] m_be(input logic [3:0] op, input logic [31:0] a);
    int sz = m_size(op);
    return ((32'd1 << sz) - 32'd1) << (a % 4);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] sd);
    case (m_size(op))
      1:       return (sd & 32'hFF) * 32'h0101_0101;
      2:       return (sd & 32'hFFFF) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] word);
    logic [31:0] v = word >> (8 * (a % 4));
    logic [31:0] r;
    case (op)
      T_LB:  begin r = v & 32'hFF;   if (r >= 32'd128)   r = r - 32'd256;   end
      T_LBU: r = v & 32'hFF;
      T_LH:  begin r = v & 32'hFFFF; if (r >= 32'd32768) r = r - 32'd65536; end
      T_LHU: r = v & 32'hFFFF;
      T_LW:  r = word;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Called about 1 ns after a rising edge with the unit in IDLE; returns likewise.
  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] rd,
                        input logic [31:0] word, input int delay);
    bit ld = m_is_load(op);
    check(nm, "ready_before", ex_ready, 1);
    ex_valid = 1; mem_op = op; addr = a; store_data = sd; rd_addr = rd;
    @(posedge clk); #1;
    ex_valid = 0; mem_op = 4'($urandom); addr = $urandom; store_data = $urandom;
    rd_addr = 5'($urandom);
    if (m_size(op) == 0) begin
      check(nm, "nop_req", dmem_req, 0);
      check(nm, "nop_wbv", wb_valid, 0);
      check(nm, "nop_mis", misaligned, 0);
      check(nm, "nop_ready", ex_ready, 1);
    end else if (m_misaligned(op, a)) begin
      check(nm, "mis_pulse", misaligned, 1);
      check(nm, "mis_req", dmem_req, 0);
      check(nm, "mis_wbv", wb_valid, 0);
      check(nm, "mis_ready", ex_ready, 1);
      @(posedge clk); #1;
      check(nm, "mis_drop", misaligned, 0);
      check(nm, "mis_req2", dmem_req, 0);
      check(nm, "mis_wbv2", wb_valid, 0);
    end else begin
      for (int c = 0; c <= delay; c++) begin
        check(nm, "req", dmem_req, 1);
        check(nm, "ready_low", ex_ready, 0);
        check(nm, "acc_wbv", wb_valid, 0);
        check(nm, "addr", dmem_addr, {a[31:2], 2'b00});
        check(nm, "be", {28'd0, dmem_be}, m_be(op, a));
        check(nm, "we", dmem_we, !ld);
        if (!ld) check(nm, "wdata", dmem_wdata, m_wdata(op, sd));
        if (c == delay) begin
          dmem_ack = 1; dmem_rdata = word; ex_valid = 0;
        end else begin
          dmem_ack = 0; dmem_rdata = $urandom; ex_valid = 1; mem_op = T_SW; addr = $urandom;
        end
        @(posedge clk); #1;
      end
      dmem_ack = 0; dmem_rdata = $urandom;
      check(nm, "wb_valid", wb_valid, 1);
      check(nm, "req_drop", dmem_req, 0);
      check(nm, "resp_ready", ex_ready, 0);
      check(nm, "wb_write", wb_write, ld && (rd != 0));
      check(nm, "wb_rd", {27'd0, wb_rd_addr}, {27'd0, rd});
      check(nm, "wb_data", wb_data, ld ? m_load(op, a, word) : 32'd0);
      @(posedge clk); #1;
      check(nm, "wbv_pulse", wb_valid, 0);
      check(nm, "ready_after", ex_ready, 1);
      check(nm, "no_mis", misaligned, 0);
    end
  endtask

  initial begin
    rst_n = 0; ex_valid = 0; mem_op = 0; addr = 0; store_data = 0; rd_addr = 0;
    dmem_ack = 0; dmem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", "ready", ex_ready, 1);
    check("reset", "req", dmem_req, 0);
    check("reset", "wbv", wb_valid, 0);
    check("reset", "mis", misaligned, 0);
    check("reset", "be", {28'd0, dmem_be}, 0);
    check("reset", "wb_data", wb_data, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    run_op("lw_basic", T_LW, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0);
    check("lw_const", "wb_expect", m_load(T_LW, 32'h100, 32'hDEADBEEF), 32'hDEADBEEF);
    run_op("lb_103", T_LB, 32'h103, 32'h0, 5'd3, 32'h80FF1234, 0);
    run_op("lbu_103", T_LBU, 32'h103, 32'h0, 5'd4, 32'h80FF1234, 1);
    run_op("sh_202", T_SH, 32'h202, 32'h0000ABCD, 5'd9, 32'h12345678, 3);
    run_op("lw_101", T_LW, 32'h101, 32'h0, 5'd6, 32'h0, 0);
    run_op("sh_301", T_SH, 32'h301, 32'h1111, 5'd6, 32'h0, 0);
    run_op("lw_rd0", T_LW, 32'h40, 32'h0, 5'd0, 32'hCAFEF00D, 2);
    run_op("lh_neg", T_LH, 32'h12, 32'h0, 5'd7, 32'h8001_7FFF, 0);
    run_op("lhu_hi", T_LHU, 32'h12, 32'h0, 5'd8, 32'h8001_7FFF, 0);
    run_op("sb_1", T_SB, 32'h81, 32'hFFFF_FF5A, 5'd1, 32'h0, 1);
    run_op("nop", T_NOP, 32'h3, 32'h0, 5'd2, 32'h0, 0);
    run_op("illegal", 4'd13, 32'h0, 32'h0, 5'd2, 32'h0, 0);

    dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dmem_ack = 0;
    check("stray_ack", "req", dmem_req, 0);
    check("stray_ack", "wbv", wb_valid, 0);
    check("stray_ack", "ready", ex_ready, 1);
    check("stray_ack", "mis", misaligned, 0);

    ex_valid = 1; mem_op = T_LW; addr = 32'h400; rd_addr = 5'd7;
    @(posedge clk); #1;
    ex_valid = 0;
    check("rst_mid", "req_before", dmem_req, 1);
    #2 rst_n = 0;
    #1;
    check("rst_mid", "req_async", dmem_req, 0);
    check("rst_mid", "ready", ex_ready, 1);
    check("rst_mid", "wbv", wb_valid, 0);
    check("rst_mid", "addr", dmem_addr, 0);
    check("rst_mid", "be", {28'd0, dmem_be}, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    check("rst_rel", "ready", ex_ready, 1);
    check("rst_rel", "wbv", wb_valid, 0);
    check("rst_rel", "req", dmem_req, 0);
    run_op("sw_after_rst", T_SW, 32'h0, 32'h1234_5678, 5'd3, 32'h0, 1);

    for (int i = 0; i < 60; i++) begin
      logic [3:0] op = 4'($urandom_range(0, 15));
      logic [31:0] a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_op("random", op, a, $urandom, 5'($urandom), $urandom, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the execute-stage ALU.
- Consumes the ALU result as the effective address, plus rs2 store data and a memory op code.
- Runs a request/acknowledge transaction on the data-memory port, then returns lane-aligned, sign- or zero-extended load data with the destination tag to writeback.
- Stalls execute (EX_READY low) while a transaction is outstanding.

Parameters:
- DATA_WIDTH, 32, data and address width.
- REG_ADDR_WIDTH, 5, destination register tag width.
- MEM_OP_WIDTH, 4, width of MEM_OP.

Ports:
- CLK  input  1  single clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- EX_VALID  input  1  execute stage presents an operation.
- EX_READY  output  1  unit can accept an operation this cycle.
- MEM_OP  input  4  0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; all other codes are treated as NOP.
- ADDR  input  32  effective address (ALU output).
- STORE_DATA  input  32  rs2 value.
- RD_ADDR  input  5  load destination register.
- DMEM_REQ  output  1  memory request valid.
- DMEM_WE  output  1  1 = write.
- DMEM_ADDR  output  32  word-aligned address ({ADDR[31:2],2'b00}).
- DMEM_BE  output  4  byte enables.
- DMEM_WDATA  output  32  lane-replicated store data.
- DMEM_ACK  input  1  memory completes the request this cycle.
- DMEM_RDATA  input  32  read word, valid when DMEM_ACK is high.
- WB_VALID  output  1  one-cycle completion pulse.
- WB_WRITE  output  1  register-file write enable (loads only, and only when rd is not 0).
- WB_RD_ADDR  output  5  destination tag.
- WB_DATA  output  32  extended load data; 0 for stores.
- MISALIGNED  output  1  one-cycle exception pulse.

Behaviour:
- States:
  - IDLE: EX_READY=1.
  - ACCESS: DMEM_REQ=1.
  - RESP: WB_VALID=1.
- EX_READY is decoded from the state: 1 only in IDLE. Accept occurs when EX_VALID and EX_READY are both high at a rising edge.
- IDLE, accept of NOP or an illegal code: no effect, remain IDLE.
- IDLE, accept of a misaligned op: no memory request, no WB_VALID, MISALIGNED=1 for exactly the next cycle, remain IDLE.
  - LH/LHU/SH misaligned when ADDR[0]=1.
  - LW/SW misaligned when ADDR[1:0]!=0.
- IDLE, accept of an aligned op:
  - Register op, ADDR[1:0] and RD_ADDR.
  - Drive DMEM_ADDR/BE/WE/WDATA registered.
  - Move to ACCESS.
- ACCESS: all DMEM_* outputs are held stable until DMEM_ACK is sampled high.
  - For a load, DMEM_RDATA is captured on that edge.
  - DMEM_REQ deasserts on the same edge, and the state moves to RESP.
  - There is no timeout; the unit waits indefinitely for ACK.
- RESP: WB_VALID=1 for one cycle with WB_WRITE/WB_RD_ADDR/WB_DATA valid, then IDLE.
- Minimum latency: accept at edge 0; DMEM_REQ high in cycle 1; with ACK in cycle 1, WB_VALID is high in cycle 2 and EX_READY is high again in cycle 3.
- Byte enables:
  - SB/LB/LBU: BE = 1<<ADDR[1:0].
  - SH/LH/LHU: 0011 when ADDR[1]=0, else 1100.
  - SW/LW: 1111.
- Store data: SB replicates byte[7:0] into all four lanes; SH replicates half[15:0] into both halves; SW passes the word through. DMEM_WE=1 for stores, 0 for loads.
- Load data: select lane by registered ADDR[1:0].
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- DMEM_ACK outside ACCESS is ignored; EX_VALID outside IDLE is ignored (not latched).
- Reset (asynchronous, mid-transaction included):
  - State goes to IDLE immediately; DMEM_REQ drops immediately; any in-flight transaction is abandoned.
  - All registered outputs go to 0; EX_READY=1.

Decomposition:
- Shared package/include holds:
  - MEM_OP encodings.
  - FSM state encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2).
  - Byte-enable constants.
- Sub-module load_store_align: purely combinational. Takes op and byte offset; produces BE, replicated WDATA, misaligned flag and extended load data. Instantiated twice: request side and response side.

Test Plan:
- LW at 0x100, ACK in the first ACCESS cycle, RDATA=0xDEADBEEF, rd=5 -> DMEM_BE=1111, WE=0; WB_VALID high in cycle 2 with WB_DATA=0xDEADBEEF, WB_WRITE=1, WB_RD_ADDR=5.
- LB at 0x103 and LBU at 0x103, RDATA=0x80FF1234 -> BE=1000; LB gives WB_DATA=0xFFFFFF80, LBU gives 0x00000080.
- SH at 0x202, STORE_DATA=0x0000ABCD, ACK delayed 3 cycles -> DMEM_ADDR=0x200, BE=1100, WDATA=0xABCDABCD, WE=1, held stable 3 cycles; EX_READY=0 throughout; WB_VALID with WB_WRITE=0.
- LW at 0x101 and SH at 0x301 -> MISALIGNED pulses one cycle each; DMEM_REQ stays 0; WB_VALID stays 0.
- LW with rd=0 -> WB_VALID=1, WB_WRITE=0; EX_VALID asserted during ACCESS -> not accepted; stray ACK in IDLE -> no output change.
- RST_N low during ACCESS -> DMEM_REQ=0 asynchronously; after release: EX_READY=1, WB_VALID=0, and a following SW at 0x0 completes normally.
